// File: rtl/nasti_rd_arb_if.sv
// NASTI read-address (AR) and read-data (R) channel bundles with master/slave views.
interface nasti_ar #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (
        output id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid,
        input  ready
    );
    modport slave (
        input  id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid,
        output ready
    );
endinterface

interface nasti_r #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    // master receives read data; slave returns it
    modport master (
        input  id, data, resp, last, user, valid,
        output ready
    );
    modport slave (
        output id, data, resp, last, user, valid,
        input  ready
    );
endinterface

// File: rtl/nasti_rd_arb.sv
// Two-master round-robin NASTI read arbiter; one outstanding burst at a time.
module nasti_rd_arb #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    nasti_ar.slave  m0_ar,
    nasti_r.slave   m0_r,
    nasti_ar.slave  m1_ar,
    nasti_r.slave   m1_r,
    nasti_ar.master s_ar,
    nasti_r.master  s_r
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   lst_q, lst_d;

    logic [ID_WIDTH-1:0]   ar_id_c;
    logic [ADDR_WIDTH-1:0] ar_addr_c;
    logic [7:0]            ar_len_c;
    logic [2:0]            ar_size_c;
    logic [1:0]            ar_burst_c;
    logic                  ar_lock_c;
    logic [3:0]            ar_cache_c;
    logic [2:0]            ar_prot_c;
    logic [3:0]            ar_qos_c;
    logic [3:0]            ar_region_c;
    logic [USER_WIDTH-1:0] ar_user_c;
    logic                  ar_valid_c;
    logic [DATA_WIDTH-1:0] r_data_c;
    logic                  r_ready_c;

    // Granted master's AR payload; selected by the registered grant only.
    always_comb begin
        if (gnt_q) begin
            ar_id_c     = m1_ar.id;
            ar_addr_c   = m1_ar.addr;
            ar_len_c    = m1_ar.len;
            ar_size_c   = m1_ar.size;
            ar_burst_c  = m1_ar.burst;
            ar_lock_c   = m1_ar.lock;
            ar_cache_c  = m1_ar.cache;
            ar_prot_c   = m1_ar.prot;
            ar_qos_c    = m1_ar.qos;
            ar_region_c = m1_ar.region;
            ar_user_c   = m1_ar.user;
            ar_valid_c  = m1_ar.valid;
            r_ready_c   = m1_r.ready;
        end else begin
            ar_id_c     = m0_ar.id;
            ar_addr_c   = m0_ar.addr;
            ar_len_c    = m0_ar.len;
            ar_size_c   = m0_ar.size;
            ar_burst_c  = m0_ar.burst;
            ar_lock_c   = m0_ar.lock;
            ar_cache_c  = m0_ar.cache;
            ar_prot_c   = m0_ar.prot;
            ar_qos_c    = m0_ar.qos;
            ar_region_c = m0_ar.region;
            ar_user_c   = m0_ar.user;
            ar_valid_c  = m0_ar.valid;
            r_ready_c   = m0_r.ready;
        end
    end

    assign r_data_c = s_r.data;

    // Next-state and channel steering; every handshake signal defaults low.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        lst_d   = lst_q;

        s_ar.id     = ar_id_c;
        s_ar.addr   = ar_addr_c;
        s_ar.len    = ar_len_c;
        s_ar.size   = ar_size_c;
        s_ar.burst  = ar_burst_c;
        s_ar.lock   = ar_lock_c;
        s_ar.cache  = ar_cache_c;
        s_ar.prot   = ar_prot_c;
        s_ar.qos    = ar_qos_c;
        s_ar.region = ar_region_c;
        s_ar.user   = ar_user_c;
        s_ar.valid  = 1'b0;
        m0_ar.ready = 1'b0;
        m1_ar.ready = 1'b0;

        s_r.ready  = 1'b0;
        m0_r.id    = s_r.id;
        m0_r.data  = r_data_c;
        m0_r.resp  = s_r.resp;
        m0_r.last  = s_r.last;
        m0_r.user  = s_r.user;
        m0_r.valid = 1'b0;
        m1_r.id    = s_r.id;
        m1_r.data  = r_data_c;
        m1_r.resp  = s_r.resp;
        m1_r.last  = s_r.last;
        m1_r.user  = s_r.user;
        m1_r.valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_ar.valid && m1_ar.valid) begin
                    gnt_d   = ~lst_q;
                    state_d = ST_ADDR;
                end else if (m0_ar.valid) begin
                    gnt_d   = 1'b0;
                    state_d = ST_ADDR;
                end else if (m1_ar.valid) begin
                    gnt_d   = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                s_ar.valid = ar_valid_c;
                if (gnt_q) begin
                    m1_ar.ready = s_ar.ready;
                end else begin
                    m0_ar.ready = s_ar.ready;
                end
                if (ar_valid_c && s_ar.ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                s_r.ready = r_ready_c;
                if (gnt_q) begin
                    m1_r.valid = s_r.valid;
                end else begin
                    m0_r.valid = s_r.valid;
                end
                if (s_r.valid && r_ready_c && s_r.last) begin
                    lst_d   = gnt_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            lst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            lst_q   <= lst_d;
        end
    end
endmodule

// File: tb/tb_nasti_rd_arb.sv
// Bench for nasti_rd_arb: directed scenarios plus randomized traffic against a grant/beat model.
module tb_nasti_rd_arb;
    localparam int unsigned IDW = 1;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned UW  = 1;
    localparam int unsigned ARW = IDW + AW + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + UW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   mdl_lst = 1'b1;
    logic [ARW-1:0] ar_bits [2];
    logic [7:0]     ar_len  [2];

    nasti_ar #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) m0_ar ();
    nasti_ar #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) m1_ar ();
    nasti_ar #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) s_ar ();
    nasti_r  #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m0_r ();
    nasti_r  #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m1_r ();
    nasti_r  #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_r ();

    nasti_rd_arb #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_ar(m0_ar), .m0_r(m0_r), .m1_ar(m1_ar), .m1_r(m1_r),
        .s_ar(s_ar), .s_r(s_r)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Reference grant rule: single requester wins, contention alternates from last served.
    function automatic bit mdl_grant(input bit v0, input bit v1);
        if (v0 && v1) return ~mdl_lst;
        if (v1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [ARW-1:0] s_ar_bits();
        return {s_ar.id, s_ar.addr, s_ar.len, s_ar.size, s_ar.burst, s_ar.lock,
                s_ar.cache, s_ar.prot, s_ar.qos, s_ar.region, s_ar.user};
    endfunction

    task automatic set_ar(input bit m, input logic v, input logic [AW-1:0] a, input logic [7:0] l);
        logic [ARW-1:0] b;
        b = {IDW'($urandom), a, l, 3'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
             3'($urandom), 4'($urandom), 4'($urandom), UW'($urandom)};
        ar_bits[m] = b;
        ar_len[m]  = l;
        if (m == 1'b0) begin
            {m0_ar.id, m0_ar.addr, m0_ar.len, m0_ar.size, m0_ar.burst, m0_ar.lock,
             m0_ar.cache, m0_ar.prot, m0_ar.qos, m0_ar.region, m0_ar.user} = b;
            m0_ar.valid = v;
        end else begin
            {m1_ar.id, m1_ar.addr, m1_ar.len, m1_ar.size, m1_ar.burst, m1_ar.lock,
             m1_ar.cache, m1_ar.prot, m1_ar.qos, m1_ar.region, m1_ar.user} = b;
            m1_ar.valid = v;
        end
    endtask

    task automatic set_valid(input bit m, input logic v);
        if (m == 1'b0) m0_ar.valid = v;
        else           m1_ar.valid = v;
    endtask

    task automatic set_rready(input bit m, input logic r);
        if (m == 1'b0) m0_r.ready = r;
        else           m1_r.ready = r;
    endtask

    task automatic put_r(input logic v, input logic [DW-1:0] d, input logic l);
        s_r.valid = v;
        s_r.data  = d;
        s_r.last  = l;
        s_r.id    = '0;
        s_r.resp  = '0;
        s_r.user  = '0;
    endtask

    task automatic idle_inputs();
        set_ar(1'b0, 1'b0, '0, 8'd0);
        set_ar(1'b1, 1'b0, '0, 8'd0);
        s_ar.ready = 1'b0;
        put_r(1'b0, '0, 1'b0);
        m0_r.ready = 1'b0;
        m1_r.ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        mdl_lst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        set_ar(1'b0, 1'b1, 8'h11, 8'd0);
        set_ar(1'b1, 1'b1, 8'h22, 8'd0);
        s_ar.ready = 1'b1;
        put_r(1'b1, 8'hA5, 1'b1);
        m0_r.ready = 1'b1;
        m1_r.ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (s_ar.valid !== 1'b0) begin failures++; $display("FAIL reset_s_ar_valid: got %b want 0", s_ar.valid); end
        checks++; if (s_r.ready !== 1'b0) begin failures++; $display("FAIL reset_s_r_ready: got %b want 0", s_r.ready); end
        checks++; if (m0_ar.ready !== 1'b0) begin failures++; $display("FAIL reset_m0_ar_ready: got %b want 0", m0_ar.ready); end
        checks++; if (m1_ar.ready !== 1'b0) begin failures++; $display("FAIL reset_m1_ar_ready: got %b want 0", m1_ar.ready); end
        checks++; if (m0_r.valid !== 1'b0) begin failures++; $display("FAIL reset_m0_r_valid: got %b want 0", m0_r.valid); end
        checks++; if (m1_r.valid !== 1'b0) begin failures++; $display("FAIL reset_m1_r_valid: got %b want 0", m1_r.valid); end
        next_cycle();
        rst = 1'b0;
        mdl_lst = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++; if (s_ar.valid !== 1'b0 || s_r.ready !== 1'b0 || m0_r.valid !== 1'b0 || m1_r.valid !== 1'b0)
            begin failures++; $display("FAIL reset_release_idle: s_ar.valid=%b s_r.ready=%b want 0", s_ar.valid, s_r.ready); end
        next_cycle();
    endtask

    task automatic test_single();
        logic [DW-1:0] d [4];
        bit g;
        for (int b = 0; b < 4; b++) d[b] = DW'($urandom);
        set_ar(1'b0, 1'b1, 8'h40, 8'd3);
        g = mdl_grant(1'b1, 1'b0);
        s_ar.ready = 1'b1;
        m0_r.ready = 1'b1;
        m1_r.ready = 1'b1;
        @(negedge clk);
        checks++; if (s_ar.valid !== 1'b0) begin failures++; $display("FAIL single_latency: s_ar.valid=%b want 0 same cycle", s_ar.valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (s_ar.valid !== 1'b1) begin failures++; $display("FAIL single_ar_valid: got %b want 1", s_ar.valid); end
        checks++; if (s_ar.addr !== 8'h40 || s_ar.len !== 8'd3) begin failures++; $display("FAIL single_ar_addr: addr=%h len=%0d want 40/3", s_ar.addr, s_ar.len); end
        checks++; if (m0_ar.ready !== 1'b1 || m1_ar.ready !== 1'b0) begin failures++; $display("FAIL single_ar_ready: m0=%b m1=%b want 1/0", m0_ar.ready, m1_ar.ready); end
        next_cycle();
        set_valid(1'b0, 1'b0);
        s_ar.ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            put_r(1'b1, d[b], 1'(b == 3));
            @(negedge clk);
            checks++; if (m0_r.valid !== 1'b1 || m0_r.data !== d[b]) begin failures++; $display("FAIL single_beat%0d: valid=%b data=%h want 1/%h", b, m0_r.valid, m0_r.data, d[b]); end
            checks++; if (m0_r.last !== 1'(b == 3)) begin failures++; $display("FAIL single_last%0d: got %b want %b", b, m0_r.last, 1'(b == 3)); end
            checks++; if (m1_r.valid !== 1'b0 || s_r.ready !== 1'b1) begin failures++; $display("FAIL single_other%0d: m1_r.valid=%b s_r.ready=%b want 0/1", b, m1_r.valid, s_r.ready); end
            next_cycle();
        end
        put_r(1'b0, '0, 1'b0);
        mdl_lst = g;
        @(negedge clk);
        checks++; if (m0_r.valid !== 1'b0 || s_r.ready !== 1'b0) begin failures++; $display("FAIL single_done_idle: m0_r.valid=%b s_r.ready=%b want 0", m0_r.valid, s_r.ready); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int order [3];
        order[0] = 0; order[1] = 1; order[2] = 0;
        do_reset();
        m0_r.ready = 1'b1;
        m1_r.ready = 1'b1;
        s_ar.ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            bit g;
            int got;
            logic [DW-1:0] d;
            set_ar(1'b0, 1'b1, AW'($urandom), 8'd0);
            set_ar(1'b1, 1'b1, AW'($urandom), 8'd0);
            g = mdl_grant(1'b1, 1'b1);
            d = DW'($urandom);
            next_cycle();
            @(negedge clk);
            got = (m1_ar.ready === 1'b1) ? 1 : ((m0_ar.ready === 1'b1) ? 0 : -1);
            checks++; if (got != order[r] || got != int'(g)) begin failures++; $display("FAIL rr_grant%0d: got %0d want %0d", r, got, order[r]); end
            checks++; if (s_ar_bits() !== ar_bits[g]) begin failures++; $display("FAIL rr_fields%0d: got %h want %h", r, s_ar_bits(), ar_bits[g]); end
            next_cycle();
            set_valid(g, 1'b0);
            put_r(1'b1, d, 1'b1);
            @(negedge clk);
            checks++; if ((g ? m1_r.valid : m0_r.valid) !== 1'b1 || (g ? m1_r.data : m0_r.data) !== d || (g ? m0_r.valid : m1_r.valid) !== 1'b0)
                begin failures++; $display("FAIL rr_beat%0d: winner valid=%b data=%h want 1/%h", r, (g ? m1_r.valid : m0_r.valid), (g ? m1_r.data : m0_r.data), d); end
            next_cycle();
            put_r(1'b0, '0, 1'b0);
            mdl_lst = g;
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_ar_stall();
        logic [DW-1:0] d;
        d = DW'($urandom);
        set_ar(1'b0, 1'b1, AW'($urandom), 8'd0);
        s_ar.ready = 1'b0;
        m0_r.ready = 1'b1;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (s_ar.valid !== 1'b1 || s_ar_bits() !== ar_bits[0]) begin failures++; $display("FAIL stall_fields%0d: valid=%b bits=%h want 1/%h", c, s_ar.valid, s_ar_bits(), ar_bits[0]); end
            checks++; if (m0_ar.ready !== 1'b0 || m1_ar.ready !== 1'b0) begin failures++; $display("FAIL stall_ready%0d: m0=%b m1=%b want 0/0", c, m0_ar.ready, m1_ar.ready); end
            next_cycle();
        end
        s_ar.ready = 1'b1;
        @(negedge clk);
        checks++; if (m0_ar.ready !== 1'b1 || s_ar.valid !== 1'b1) begin failures++; $display("FAIL stall_handshake: m0_ar.ready=%b s_ar.valid=%b want 1/1", m0_ar.ready, s_ar.valid); end
        next_cycle();
        set_valid(1'b0, 1'b0);
        s_ar.ready = 1'b0;
        put_r(1'b1, d, 1'b1);
        @(negedge clk);
        checks++; if (m0_r.valid !== 1'b1 || m0_r.data !== d) begin failures++; $display("FAIL stall_beat: valid=%b data=%h want 1/%h", m0_r.valid, m0_r.data, d); end
        next_cycle();
        mdl_lst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_r_backpressure();
        logic [DW-1:0] d [2];
        logic [DW-1:0] got [$];
        bit pat [4];
        int bi;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        d[0] = DW'($urandom);
        d[1] = DW'($urandom);
        bi = 0;
        set_ar(1'b1, 1'b1, AW'($urandom), 8'd1);
        s_ar.ready = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (m1_ar.ready !== 1'b1 || m0_ar.ready !== 1'b0) begin failures++; $display("FAIL bp_grant: m1=%b m0=%b want 1/0", m1_ar.ready, m0_ar.ready); end
        next_cycle();
        set_valid(1'b1, 1'b0);
        s_ar.ready = 1'b0;
        m0_r.ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bi < 2) put_r(1'b1, d[bi], 1'(bi == 1));
            else        put_r(1'b0, '0, 1'b0);
            m1_r.ready = pat[c];
            @(negedge clk);
            checks++; if (s_r.ready !== pat[c]) begin failures++; $display("FAIL bp_ready%0d: s_r.ready=%b want %b", c, s_r.ready, pat[c]); end
            checks++; if (m0_r.valid !== 1'b0) begin failures++; $display("FAIL bp_m0_valid%0d: got %b want 0", c, m0_r.valid); end
            if (m1_r.valid === 1'b1 && pat[c]) got.push_back(m1_r.data);
            if (s_r.valid && pat[c]) bi++;
            next_cycle();
        end
        checks++; if (got.size() != 2) begin failures++; $display("FAIL bp_count: got %0d beats want 2", got.size()); end
        else begin
            checks++; if (got[0] !== d[0] || got[1] !== d[1]) begin failures++; $display("FAIL bp_order: got %h,%h want %h,%h", got[0], got[1], d[0], d[1]); end
        end
        mdl_lst = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] d;
        bit g;
        d = DW'($urandom);
        set_ar(1'b0, 1'b1, AW'($urandom), 8'd7);
        s_ar.ready = 1'b1;
        m0_r.ready = 1'b1;
        next_cycle();
        next_cycle();
        set_valid(1'b0, 1'b0);
        s_ar.ready = 1'b0;
        put_r(1'b1, DW'($urandom), 1'b0);
        @(negedge clk);
        checks++; if (m0_r.valid !== 1'b1) begin failures++; $display("FAIL rstmid_beat1: m0_r.valid=%b want 1", m0_r.valid); end
        next_cycle();
        put_r(1'b1, DW'($urandom), 1'b0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mdl_lst = 1'b1;
        set_ar(1'b1, 1'b1, AW'($urandom), 8'd0);
        g = mdl_grant(1'b0, 1'b1);
        s_ar.ready = 1'b1;
        @(negedge clk);
        checks++; if (s_ar.valid !== 1'b0 || m0_ar.ready !== 1'b0 || m1_ar.ready !== 1'b0)
            begin failures++; $display("FAIL rstmid_ar: s_ar.valid=%b m0=%b m1=%b want 0", s_ar.valid, m0_ar.ready, m1_ar.ready); end
        checks++; if (s_r.ready !== 1'b0 || m0_r.valid !== 1'b0 || m1_r.valid !== 1'b0)
            begin failures++; $display("FAIL rstmid_r: s_r.ready=%b m0_r.valid=%b m1_r.valid=%b want 0", s_r.ready, m0_r.valid, m1_r.valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (m1_ar.ready !== 1'b1 || s_ar.valid !== 1'b1 || s_ar_bits() !== ar_bits[g])
            begin failures++; $display("FAIL rstmid_regrant: m1_ar.ready=%b s_ar.valid=%b bits=%h want 1/1/%h", m1_ar.ready, s_ar.valid, s_ar_bits(), ar_bits[g]); end
        checks++; if (m0_r.valid !== 1'b0 || m1_r.valid !== 1'b0 || s_r.ready !== 1'b0)
            begin failures++; $display("FAIL rstmid_stall: m1_r.valid=%b s_r.ready=%b want 0/0", m1_r.valid, s_r.ready); end
        next_cycle();
        set_valid(1'b1, 1'b0);
        s_ar.ready = 1'b0;
        m1_r.ready = 1'b1;
        put_r(1'b1, d, 1'b1);
        @(negedge clk);
        checks++; if (m1_r.valid !== 1'b1 || m1_r.data !== d) begin failures++; $display("FAIL rstmid_m1_beat: valid=%b data=%h want 1/%h", m1_r.valid, m1_r.data, d); end
        next_cycle();
        mdl_lst = g;
        idle_inputs();
    endtask

    task automatic test_idle_r();
        put_r(1'b1, DW'($urandom), 1'b1);
        m0_r.ready = 1'b1;
        m1_r.ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (s_r.ready !== 1'b0) begin failures++; $display("FAIL idle_r_ready%0d: got %b want 0", c, s_r.ready); end
            checks++; if (m0_r.valid !== 1'b0 || m1_r.valid !== 1'b0) begin failures++; $display("FAIL idle_r_valid%0d: m0=%b m1=%b want 0", c, m0_r.valid, m1_r.valid); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            bit v0, v1, g;
            int nb, bi, cyc, stall;
            logic [DW-1:0] q [$];
            logic sv, mr;
            idle_inputs();
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            if (v0) set_ar(1'b0, 1'b1, AW'($urandom), 8'($urandom_range(0, 3)));
            if (v1) set_ar(1'b1, 1'b1, AW'($urandom), 8'($urandom_range(0, 3)));
            g = mdl_grant(v0, v1);
            @(negedge clk);
            checks++; if (s_ar.valid !== 1'b0) begin failures++; $display("FAIL rand_idle_gap%0d: s_ar.valid=%b want 0", t, s_ar.valid); end
            next_cycle();
            stall = $urandom_range(0, 2);
            for (int c = 0; c <= stall; c++) begin
                s_ar.ready = 1'(c == stall);
                @(negedge clk);
                checks++; if (s_ar.valid !== 1'b1 || s_ar_bits() !== ar_bits[g])
                    begin failures++; $display("FAIL rand_ar_fwd%0d: valid=%b bits=%h want 1/%h (gnt %0d)", t, s_ar.valid, s_ar_bits(), ar_bits[g], g); end
                checks++; if ((g ? m1_ar.ready : m0_ar.ready) !== 1'(c == stall) || (g ? m0_ar.ready : m1_ar.ready) !== 1'b0)
                    begin failures++; $display("FAIL rand_ar_ready%0d: m0=%b m1=%b gnt %0d", t, m0_ar.ready, m1_ar.ready, g); end
                next_cycle();
            end
            s_ar.ready  = 1'b0;
            m0_ar.valid = 1'b0;
            m1_ar.valid = 1'b0;
            nb = int'(ar_len[g]) + 1;
            q.delete();
            for (int b = 0; b < nb; b++) q.push_back(DW'($urandom));
            bi  = 0;
            cyc = 0;
            while (bi < nb && cyc < 200) begin
                sv = 1'($urandom_range(0, 3) != 0);
                mr = 1'($urandom);
                put_r(sv, q[bi], 1'(bi == nb - 1));
                set_rready(g, mr);
                set_rready(~g, 1'($urandom));
                @(negedge clk);
                checks++; if ((g ? m1_r.valid : m0_r.valid) !== sv || (g ? m0_r.valid : m1_r.valid) !== 1'b0)
                    begin failures++; $display("FAIL rand_r_valid%0d: m0=%b m1=%b want gnt %0d valid=%b", t, m0_r.valid, m1_r.valid, g, sv); end
                checks++; if (s_r.ready !== mr) begin failures++; $display("FAIL rand_r_ready%0d: got %b want %b", t, s_r.ready, mr); end
                if (sv && mr) begin
                    checks++; if ((g ? m1_r.data : m0_r.data) !== q[bi] || (g ? m1_r.last : m0_r.last) !== 1'(bi == nb - 1))
                        begin failures++; $display("FAIL rand_r_beat%0d: beat %0d data=%h want %h", t, bi, (g ? m1_r.data : m0_r.data), q[bi]); end
                    bi++;
                end
                next_cycle();
                cyc++;
            end
            checks++; if (bi != nb) begin failures++; $display("FAIL rand_burst_done%0d: %0d of %0d beats", t, bi, nb); end
            put_r(1'b0, '0, 1'b0);
            mdl_lst = g;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ar_stall();
        test_r_backpressure();
        test_reset_mid_burst();
        test_idle_r();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nasti_rd_arb.md
NASTI_RD_ARB -- requirements
Module: nasti_rd_arb

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 1, meaning the AR/R id width, carried unchanged between masters and slave.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the AR address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, meaning the R data width.
REQ-004 The block SHALL have parameter USER_WIDTH, default 1, meaning the AR/R user width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port m0_ar, nasti_ar.slave, parameterised width: master 0 read-address channel.
REQ-008 The block SHALL have port m0_r, nasti_r.slave, parameterised width: master 0 read-data channel.
REQ-009 The block SHALL have port m1_ar, nasti_ar.slave, parameterised width: master 1 read-address channel.
REQ-010 The block SHALL have port m1_r, nasti_r.slave, parameterised width: master 1 read-data channel.
REQ-011 The block SHALL have port s_ar, nasti_ar.master, parameterised width: shared downstream read-address channel.
REQ-012 The block SHALL have port s_r, nasti_r.master, parameterised width: shared downstream read-data channel.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, ADDR, DATA.
REQ-014 The block SHALL keep one grant register gnt (0 or 1) and one last-served register lst (0 or 1).
REQ-015 IDLE: if exactly one mX_ar.valid=1, the block SHALL load gnt=X and enter ADDR on the next edge.
REQ-016 IDLE: if both masters are valid, the block SHALL load gnt = !lst (round-robin) and enter ADDR.
REQ-017 IDLE: if neither master is valid, the block SHALL remain in IDLE.
REQ-018 In IDLE, all ready and valid outputs SHALL be 0, with no combinational path from any mX_ar.valid to s_ar.valid; address latency is therefore exactly 1 cycle from master valid to s_ar.valid.
REQ-019 ADDR: s_ar id/addr/len/size/burst/lock/cache/prot/qos/region/user/valid SHALL equal the granted master's fields.
REQ-020 ADDR: the granted master's ar.ready SHALL equal s_ar.ready; the other master's ar.ready SHALL be 0.
REQ-021 ADDR: on s_ar.valid & s_ar.ready, the block SHALL enter DATA.
REQ-022 ADDR: if the granted master drops valid before the handshake (protocol violation), the block SHALL remain in ADDR with s_ar.valid=0 and SHALL NOT regrant.
REQ-023 DATA: the granted master's r id/data/resp/last/user/valid SHALL equal s_r's fields, and s_r.ready SHALL equal the granted master's r.ready.
REQ-024 DATA: the non-granted master's r.valid SHALL be 0; its r data fields are don't-care.
REQ-025 DATA: s_ar.valid and both mX_ar.ready SHALL be 0, giving one outstanding burst at a time.
REQ-026 DATA: on s_r.valid & s_r.ready & s_r.last, the block SHALL set lst=gnt and return to IDLE on the next edge.
REQ-027 A burst of len+1 beats SHALL be forwarded beat-for-beat with zero added latency, honouring backpressure on every beat.
REQ-028 Outside DATA, all mX_r.valid and s_r.ready SHALL be 0; R beats arriving in IDLE/ADDR SHALL be stalled, never dropped.
REQ-029 The turnaround from the last-beat handshake to the next s_ar.valid SHALL be 2 cycles: IDLE, then ADDR.

Reset
REQ-030 When rst=1 at a rising edge, the block SHALL set state=IDLE, gnt=0, lst=1, so master 0 wins the first contention.
REQ-031 During and after reset, s_ar.valid, s_r.ready, m0_ar.ready, m1_ar.ready, m0_r.valid and m1_r.valid SHALL be 0 until the FSM leaves IDLE.
REQ-032 A reset asserted mid-burst SHALL abandon the transaction immediately; the next grant SHALL follow REQ-015/016 with lst=1.

Verification
REQ-033 The bench SHALL drive m0 only, addr=0x40, len=3 -> s_ar.valid one cycle later with addr 0x40; four R beats reach m0_r with last on beat 4; m1_r.valid stays 0.
REQ-034 The bench SHALL drive m0 and m1 valid together from reset, three times in a row -> grant order 0,1,0.
REQ-035 The bench SHALL hold s_ar.ready=0 for 5 cycles in ADDR -> s_ar fields stable and m ar.ready=0 throughout; handshake on cycle 6.
REQ-036 The bench SHALL toggle m1_r.ready 1,0,1,0 during a len=1 burst to m1 -> s_r.ready mirrors it; exactly 2 beats delivered, in order.
REQ-037 The bench SHALL assert rst during beat 2 of a len=7 burst -> the next cycle shows all valid/ready outputs 0 and state IDLE; a new m1 request is granted next.
REQ-038 The bench SHALL present an s_r.valid beat while the block is in IDLE -> s_r.ready=0 and no master sees r.valid.
